// File: rtl/raggedstone_spinn_aer_if_aer_in_buffer_if.sv
// Bundled-data 4-phase active-low AER link: master drives data/req, slave drives ack.
interface raggedstone_spinn_aer_if_aer_in_buffer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             req;
  logic             ack;

  modport master (output data, output req, input ack);
  modport slave  (input data, input req, output ack);
endinterface

// File: rtl/raggedstone_spinn_aer_if_aer_in_buffer.sv
// Elastic FIFO between the synchronised AER input device and the downstream mapper,
// with independent 4-phase handshake FSMs on each side.
module raggedstone_spinn_aer_if_aer_in_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  raggedstone_spinn_aer_if_aer_in_buffer_if.slave  iaer,
  raggedstone_spinn_aer_if_aer_in_buffer_if.master maer,
  output logic [DEPTH_LOG2:0]                      occupancy,
  output logic                                     evt_pulse
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  // state     | meaning
  // IN_WAIT   | after reset, wait for device req to go high before capturing
  // IN_IDLE   | ready to capture a device event when space is available
  // IN_ACK    | event captured, ack low, wait for device req release
  // OUT_IDLE  | waiting for a stored event
  // OUT_REQ   | maer_req low with head data, wait for downstream ack
  // OUT_REL   | event popped, wait for downstream ack release
  typedef enum logic [1:0] {IN_WAIT, IN_IDLE, IN_ACK} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_REL} out_state_t;

  in_state_t             in_state;
  out_state_t            out_state;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (occupancy == FULL_CNT);
  assign empty = (occupancy == '0);
  assign push  = (in_state == IN_IDLE) && !iaer.req && !full;
  assign pop   = (out_state == OUT_REQ) && !maer.ack;

  // Storage carries no reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iaer.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state  <= IN_WAIT;
      iaer.ack  <= 1'b1;
      evt_pulse <= 1'b0;
    end else begin
      evt_pulse <= push;
      case (in_state)
        IN_WAIT: if (iaer.req) in_state <= IN_IDLE;
        IN_IDLE: begin
          if (push) begin
            iaer.ack <= 1'b0;
            in_state <= IN_ACK;
          end
        end
        IN_ACK: begin
          if (iaer.req) begin
            iaer.ack <= 1'b1;
            in_state <= IN_IDLE;
          end
        end
        default: begin
          iaer.ack <= 1'b1;
          in_state <= IN_WAIT;
        end
      endcase
    end
  end

  // maer.data is only loaded on leaving OUT_IDLE, so it stays put through the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      maer.req  <= 1'b1;
      maer.data <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (!empty) begin
            maer.data <= mem[rd_ptr];
            maer.req  <= 1'b0;
            out_state <= OUT_REQ;
          end
        end
        OUT_REQ: begin
          if (!maer.ack) begin
            maer.req  <= 1'b1;
            out_state <= OUT_REL;
          end
        end
        OUT_REL: if (maer.ack) out_state <= OUT_IDLE;
        default: begin
          maer.req  <= 1'b1;
          out_state <= OUT_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_raggedstone_spinn_aer_if_aer_in_buffer.sv
// Directed and randomised handshake bench for the AER input buffer.
module tb_raggedstone_spinn_aer_if_aer_in_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] occupancy;
  logic       evt_pulse;

  int passed = 0;
  int total  = 0;
  int viol   = 0;
  int evt_cnt = 0;

  raggedstone_spinn_aer_if_aer_in_buffer_if dev ();
  raggedstone_spinn_aer_if_aer_in_buffer_if dn ();

  raggedstone_spinn_aer_if_aer_in_buffer #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .iaer      (dev),
    .maer      (dn),
    .occupancy (occupancy),
    .evt_pulse (evt_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (evt_pulse === 1'b1) evt_cnt <= evt_cnt + 1;
  end

  // Protocol monitor on pre-edge snapshots; outputs may only move in response to the peer.
  logic        prev_rst = 1'b1;
  logic        prev_mreq, prev_mack, prev_iack, prev_ireq;
  logic [15:0] prev_mdata;
  always @(posedge clk) begin
    if (!rst && !prev_rst) begin
      viol <= viol
        + ((prev_mreq && !dn.req && !prev_mack) ? 1 : 0)
        + ((!prev_mreq && dn.req && prev_mack) ? 1 : 0)
        + ((!prev_mreq && !dn.req && (dn.data !== prev_mdata)) ? 1 : 0)
        + ((prev_iack && !dev.ack && prev_ireq) ? 1 : 0)
        + ((!prev_iack && dev.ack && !prev_ireq) ? 1 : 0);
    end
    prev_rst   <= rst;
    prev_mreq  <= dn.req;
    prev_mack  <= dn.ack;
    prev_mdata <= dn.data;
    prev_iack  <= dev.ack;
    prev_ireq  <= dev.req;
  end

  task automatic send_event(input logic [15:0] d, input int pre_dly, output bit ok);
    ok = 1'b0;
    repeat (pre_dly) @(negedge clk);
    dev.data = d;
    dev.req  = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (dev.ack === 1'b0) begin ok = 1'b1; break; end
    end
    dev.req = 1'b1;
    if (!ok) return;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dev.ack === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic recv_event(input int dly, output logic [15:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 500; i++) begin
      if (dn.req === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    repeat (dly) @(negedge clk);
    d = dn.data;
    dn.ack = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dn.req === 1'b1) begin ok = 1'b1; break; end
    end
    dn.ack = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dev.req = 1'b1;
    dev.data = '0;
    dn.ack = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dev.ack !== 1'b1) $display("FAIL reset_iaer_ack got %b want 1", dev.ack); else passed++;
    total++; if (dn.req !== 1'b1) $display("FAIL reset_maer_req got %b want 1", dn.req); else passed++;
    total++; if (dn.data !== 16'h0000) $display("FAIL reset_maer_data got %h want 0000", dn.data); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else passed++;
    total++; if (evt_pulse !== 1'b0) $display("FAIL reset_evt_pulse got %b want 0", evt_pulse); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int evt0;
    @(negedge clk);
    evt0 = evt_cnt;
    dev.data = 16'hA5C3;
    dev.req  = 1'b0;
    @(negedge clk);
    total++; if (dev.ack !== 1'b0) $display("FAIL single_ack_latency got %b want 0", dev.ack); else passed++;
    total++; if (occupancy !== 5'd1) $display("FAIL single_occ_after_push got %0d want 1", occupancy); else passed++;
    total++; if (evt_pulse !== 1'b1) $display("FAIL single_evt_pulse_high got %b want 1", evt_pulse); else passed++;
    total++; if (dn.req !== 1'b1) $display("FAIL single_req_early got %b want 1", dn.req); else passed++;
    @(negedge clk);
    total++; if (dn.req !== 1'b0) $display("FAIL single_req_latency got %b want 0", dn.req); else passed++;
    total++; if (dn.data !== 16'hA5C3) $display("FAIL single_data got %h want a5c3", dn.data); else passed++;
    total++; if (evt_pulse !== 1'b0) $display("FAIL single_evt_pulse_width got %b want 0", evt_pulse); else passed++;
    dev.req = 1'b1;
    @(negedge clk);
    total++; if (dev.ack !== 1'b1) $display("FAIL single_ack_release got %b want 1", dev.ack); else passed++;
    @(negedge clk);
    total++; if (dn.req !== 1'b0 || dn.data !== 16'hA5C3) $display("FAIL single_req_hold got req=%b data=%h want req=0 data=a5c3", dn.req, dn.data); else passed++;
    @(negedge clk);
    dn.ack = 1'b0;
    @(negedge clk);
    total++; if (dn.req !== 1'b1) $display("FAIL single_req_rise got %b want 1", dn.req); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL single_occ_after_pop got %0d want 0", occupancy); else passed++;
    total++; if (dn.data !== 16'hA5C3) $display("FAIL single_data_keep got %h want a5c3", dn.data); else passed++;
    dn.ack = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (evt_cnt - evt0 !== 1) $display("FAIL single_evt_count got %0d want 1", evt_cnt - evt0); else passed++;
  endtask

  task automatic test_full_stall;
    bit          ok;
    bit          ok17;
    int          bad;
    int          order_err;
    int          evt0;
    evt0 = evt_cnt;
    dn.ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      send_event(16'(i), 0, ok);
      if (!ok) bad++;
    end
    total++; if (bad !== 0) $display("FAIL full_fill_timeouts got %0d want 0", bad); else passed++;
    total++; if (occupancy !== 5'd16) $display("FAIL full_occupancy got %0d want 16", occupancy); else passed++;
    dev.data = 16'h0010;
    dev.req  = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (dev.ack !== 1'b1) $display("FAIL full_ack_withheld got %b want 1", dev.ack); else passed++;
    total++; if (evt_cnt - evt0 !== 16) $display("FAIL full_evt_count got %0d want 16", evt_cnt - evt0); else passed++;
    order_err = 0;
    ok17 = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (dev.ack === 1'b0) begin ok17 = 1'b1; break; end
        end
        dev.req = 1'b1;
        repeat (2) @(negedge clk);
      end
      begin
        logic [15:0] d;
        bit          okr;
        for (int j = 0; j < 17; j++) begin
          recv_event(1, d, okr);
          if (!okr || d !== 16'(j)) order_err++;
        end
      end
    join
    repeat (2) @(negedge clk);
    total++; if (ok17 !== 1'b1) $display("FAIL full_17th_accepted got %b want 1", ok17); else passed++;
    total++; if (order_err !== 0) $display("FAIL full_drain_order errors %0d want 0", order_err); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL full_drained_occ got %0d want 0", occupancy); else passed++;
    total++; if (evt_cnt - evt0 !== 17) $display("FAIL full_total_evts got %0d want 17", evt_cnt - evt0); else passed++;
  endtask

  task automatic test_push_pop_wrap;
    bit          ok;
    int          bad;
    logic [15:0] d;
    dn.ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      send_event(16'h0100 + 16'(i), 0, ok);
      if (!ok) bad++;
    end
    total++; if (bad !== 0 || occupancy !== 5'd8) $display("FAIL pp_fill got occ=%0d timeouts=%0d want occ=8 timeouts=0", occupancy, bad); else passed++;
    dev.data = 16'h0108;
    dev.req  = 1'b0;
    dn.ack   = 1'b0;
    @(negedge clk);
    total++; if (occupancy !== 5'd8) $display("FAIL pp_occupancy got %0d want 8", occupancy); else passed++;
    total++; if (dev.ack !== 1'b0 || dn.req !== 1'b1) $display("FAIL pp_both_taken got iack=%b mreq=%b want 0 1", dev.ack, dn.req); else passed++;
    total++; if (dn.data !== 16'h0100) $display("FAIL pp_popped_data got %h want 0100", dn.data); else passed++;
    dev.req = 1'b1;
    dn.ack  = 1'b1;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      recv_event(0, d, ok);
      if (!ok || d !== 16'h0101 + 16'(i)) bad++;
    end
    total++; if (bad !== 0) $display("FAIL pp_drain_order errors %0d want 0", bad); else passed++;
    bad = 0;
    fork
      begin
        bit oks;
        for (int i = 0; i < 40; i++) begin
          send_event(16'(i), 0, oks);
          if (!oks) bad++;
        end
      end
      begin
        logic [15:0] dr;
        bit          okr;
        for (int j = 0; j < 40; j++) begin
          recv_event(j % 3, dr, okr);
          if (!okr || dr !== 16'(j)) bad++;
        end
      end
    join
    repeat (2) @(negedge clk);
    total++; if (bad !== 0) $display("FAIL wrap_data errors %0d want 0", bad); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL wrap_occ got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_reset_mid;
    bit          ok;
    int          evt0;
    logic [15:0] d;
    dn.ack   = 1'b1;
    dev.data = 16'h1234;
    dev.req  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dev.ack === 1'b0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    total++; if (!ok || dn.req !== 1'b0) $display("FAIL rstmid_setup got ack_seen=%b mreq=%b want 1 0", ok, dn.req); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (dev.ack !== 1'b1) $display("FAIL rstmid_iaer_ack got %b want 1", dev.ack); else passed++;
    total++; if (dn.req !== 1'b1) $display("FAIL rstmid_maer_req got %b want 1", dn.req); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL rstmid_occ got %0d want 0", occupancy); else passed++;
    rst = 1'b0;
    evt0 = evt_cnt;
    repeat (6) @(negedge clk);
    total++; if (dev.ack !== 1'b1 || occupancy !== 5'd0 || evt_cnt !== evt0) $display("FAIL rstmid_no_recapture got ack=%b occ=%0d evts=%0d want 1 0 0", dev.ack, occupancy, evt_cnt - evt0); else passed++;
    dev.req = 1'b1;
    repeat (2) @(negedge clk);
    dev.data = 16'h5678;
    dev.req  = 1'b0;
    @(negedge clk);
    total++; if (dev.ack !== 1'b0) $display("FAIL rstmid_recapture got %b want 0", dev.ack); else passed++;
    dev.req = 1'b1;
    recv_event(0, d, ok);
    total++; if (!ok || d !== 16'h5678) $display("FAIL rstmid_data got ok=%b data=%h want 1 5678", ok, d); else passed++;
    repeat (3) @(negedge clk);
    total++; if (occupancy !== 5'd0 || dev.ack !== 1'b1) $display("FAIL rstmid_settle got occ=%0d ack=%b want 0 1", occupancy, dev.ack); else passed++;
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    int          errs;
    int          tmo;
    int          nrecv;
    int          evt0;
    errs = 0;
    tmo = 0;
    nrecv = 0;
    evt0 = evt_cnt;
    fork
      begin
        logic [15:0] v;
        bit          oks;
        for (int i = 0; i < 1000; i++) begin
          v = 16'($urandom);
          q.push_back(v);
          send_event(v, int'($urandom_range(0, 20)), oks);
          if (!oks) tmo++;
        end
      end
      begin
        logic [15:0] dr;
        bit          okr;
        for (int j = 0; j < 1000; j++) begin
          recv_event(int'($urandom_range(0, 20)), dr, okr);
          if (!okr) tmo++;
          else begin
            nrecv++;
            if (q.size() == 0) errs++;
            else if (dr !== q.pop_front()) errs++;
          end
        end
      end
    join
    repeat (3) @(negedge clk);
    total++; if (tmo !== 0) $display("FAIL rand_timeouts got %0d want 0", tmo); else passed++;
    total++; if (errs !== 0) $display("FAIL rand_sequence errors %0d want 0", errs); else passed++;
    total++; if (nrecv !== 1000 || q.size() !== 0) $display("FAIL rand_count got %0d left=%0d want 1000 0", nrecv, q.size()); else passed++;
    total++; if (evt_cnt - evt0 !== 1000) $display("FAIL rand_evt_pulses got %0d want 1000", evt_cnt - evt0); else passed++;
    total++; if (occupancy !== 5'd0) $display("FAIL rand_final_occ got %0d want 0", occupancy); else passed++;
    total++; if (viol !== 0) $display("FAIL protocol_violations got %0d want 0", viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_push_pop_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached with %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
